// File: rtl/hello_scroll_sequencer.sv
// hello_scroll_sequencer: rotation select generator for the HELLO display muxes.
// Optional build macro HELLO_SCROLL_BOUNCE_EN selects ping-pong instead of wrap-around.
module hello_scroll_sequencer #(
    parameter int TICK_DIV = 25000000,
    parameter int NUM_POS  = 5,
    parameter int SEL_W    = 3
) (
    input  logic             CLOCK_50,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Dir,
    input  logic [1:0]       Speed,
    input  logic             StepReq,
    output logic [SEL_W-1:0] Sel,
    output logic             Tick,
    output logic             Wrap,
    output logic             Running
);

    localparam int CNT_W = $clog2(TICK_DIV + 1);

    localparam logic [0:0] ST_PAUSE = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_POS - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] presc_nxt;
    logic [CNT_W-1:0] term;
    logic             run_adv;
    logic             step_adv;
    logic             adv;
    logic             eff_dir;
    logic [SEL_W-1:0] sel_nxt;
    logic             wrap_nxt;
    logic [SEL_W-1:0] sel_q;
    logic             tick_q;
    logic             wrap_q;

`ifdef HELLO_SCROLL_BOUNCE_EN
    logic             flag;
    logic             flag_nxt;
`endif

    // Terminal count for the current speed; the shift is re-evaluated every cycle
    // so a speed change takes effect on the very next compare.
    always_comb begin
        term = CNT_W'((TICK_DIV >> Speed) - 1);
    end

    // Advance sources: prescaler terminal in RUN, or a manual step while paused.
    // In RUN the step request is ignored, so a coincident step never doubles up.
    always_comb begin
        run_adv  = (state == ST_RUN) && (presc >= term);
        step_adv = (state == ST_PAUSE) && StepReq && !Enable;
        adv      = run_adv || step_adv;
    end

    // Run/pause control and prescaler next value.
    always_comb begin
        state_nxt = state;
        presc_nxt = '0;
        unique case (state)
            ST_PAUSE: begin
                if (Enable) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!Enable) begin
                    state_nxt = ST_PAUSE;
                end else if (!run_adv) begin
                    presc_nxt = presc + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_PAUSE;
            end
        endcase
    end

`ifdef HELLO_SCROLL_BOUNCE_EN
    // Ping-pong: reverse at either end instead of wrapping; Wrap marks a reversal.
    always_comb begin
        sel_nxt  = '0;
        wrap_nxt = 1'b0;
        flag_nxt = flag;
        eff_dir  = Dir ^ flag;
        if (sel_q > SEL_LAST) begin
            sel_nxt = '0;
        end else if (!eff_dir) begin
            if (sel_q == SEL_LAST) begin
                sel_nxt  = SEL_LAST - SEL_ONE;
                flag_nxt = !flag;
                wrap_nxt = 1'b1;
            end else begin
                sel_nxt = sel_q + SEL_ONE;
            end
        end else begin
            if (sel_q == '0) begin
                sel_nxt  = SEL_ONE;
                flag_nxt = !flag;
                wrap_nxt = 1'b1;
            end else begin
                sel_nxt = sel_q - SEL_ONE;
            end
        end
    end
`else
    // Wrap-around stepping in the requested direction; out-of-range recovers to 0.
    always_comb begin
        sel_nxt  = '0;
        wrap_nxt = 1'b0;
        eff_dir  = Dir;
        if (sel_q > SEL_LAST) begin
            sel_nxt = '0;
        end else if (!eff_dir) begin
            if (sel_q == SEL_LAST) begin
                sel_nxt  = '0;
                wrap_nxt = 1'b1;
            end else begin
                sel_nxt = sel_q + SEL_ONE;
            end
        end else begin
            if (sel_q == '0) begin
                sel_nxt  = SEL_LAST;
                wrap_nxt = 1'b1;
            end else begin
                sel_nxt = sel_q - SEL_ONE;
            end
        end
    end
`endif

    // Control state and prescaler registers.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_PAUSE;
            presc <= '0;
        end else begin
            state <= state_nxt;
            presc <= presc_nxt;
        end
    end

    // Select, Tick and Wrap update together on the advance edge.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= adv;
            wrap_q <= adv && wrap_nxt;
            if (adv) begin
                sel_q <= sel_nxt;
            end
        end
    end

`ifdef HELLO_SCROLL_BOUNCE_EN
    // Bounce direction flag, changes only on an advance that reverses.
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            flag <= 1'b0;
        end else if (adv) begin
            flag <= flag_nxt;
        end
    end
`endif

    // Output drive.
    always_comb begin
        Sel     = sel_q;
        Tick    = tick_q;
        Wrap    = wrap_q;
        Running = (state == ST_RUN);
    end

endmodule

// File: doc/hello_scroll_sequencer.md
Name: hello_scroll_sequencer

Overview:
- Generates the 3-bit rotation select that drives the five-way HELLO display muxes, replacing the manual select switches.
- Advances the select 0..4 at a programmable rate, with run/pause, direction and manual single-step control.
- Sits directly upstream of the mux/seven-segment stage.
- Sel feeds every mux select in parallel.

Parameters:
- TICK_DIV, 25000000, base prescaler period in clocks (0.5 s at 50 MHz); minimum 8.
- NUM_POS, 5, number of rotation positions; Sel range 0..NUM_POS-1.
- SEL_W, 3, width of Sel; must satisfy 2**SEL_W >= NUM_POS.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Enable  in  1  1 = auto-scroll, 0 = pause.
- Dir  in  1  0 = advance (Sel+1), 1 = retreat (Sel-1).
- Speed  in  2  prescaler period = TICK_DIV >> Speed.
- StepReq  in  1  single-cycle synchronous pulse; manual advance while paused.
- Sel  out  SEL_W  rotation select to the muxes.
- Tick  out  1  one-cycle pulse, high in the cycle Sel takes a new value.
- Wrap  out  1  one-cycle pulse, high when that update crossed the end of the range.
- Running  out  1  high while in RUN.

Behaviour:
- Reset (async assert, sync-to-clock release): Sel=0, Tick=0, Wrap=0, Running=0, prescaler=0, state=PAUSE. Reset mid-operation aborts immediately; no pending advance survives.
- State PAUSE:
  - Prescaler held at 0.
  - Enable=1 sampled at an edge -> RUN next cycle (Running=1 from that cycle).
  - StepReq=1 with Enable=0 -> one advance.
- State RUN:
  - Prescaler increments each clock.
  - When prescaler >= (TICK_DIV>>Speed)-1: prescaler <= 0 and one advance occurs.
  - Enable=0 sampled -> PAUSE next cycle, prescaler cleared. An advance due in that same cycle still occurs.
  - StepReq is ignored in RUN.
- Period after entering RUN: first advance occurs exactly TICK_DIV>>Speed cycles after Running rises.
- Speed change mid-count: the >= compare guarantees an advance within one cycle if the count already exceeds the new terminal. No lost or double advances.
- Advance:
  - Registered; Sel, Tick and Wrap update on the same edge. Latency = 1 clock from the advance condition.
  - Dir=0: Sel = (Sel==NUM_POS-1) ? 0 : Sel+1. Wrap=1 on the 4->0 transition.
  - Dir=1: Sel = (Sel==0) ? NUM_POS-1 : Sel-1. Wrap=1 on the 0->4 transition.
  - Dir is sampled at the advance edge only; Dir toggling between advances has no other effect.
- Simultaneous events: prescaler terminal and StepReq in the same cycle produce exactly one advance.
- Sel never leaves 0..NUM_POS-1. Out-of-range values (unreachable) are forced to 0 at the next advance.
- Tick and Wrap are 0 in every cycle without an advance.

Optional Feature:
- Macro: HELLO_SCROLL_BOUNCE_EN.
- When defined:
  - Ping-pong mode. An internal direction flag, reset to 0 (advancing), replaces wrap-around.
  - At Sel=NUM_POS-1 moving up, the flag flips and Sel becomes NUM_POS-2. At Sel=0 moving down, the flag flips and Sel becomes 1.
  - Wrap pulses on each reversal.
  - Effective direction = Dir XOR flag.
- When undefined: wrap-around exactly as in Behaviour, with no extra state.

Test Plan:
- Reset with Enable=0: assert Reset_n=0 mid-cycle -> Sel=0, Tick=0, Wrap=0, Running=0 immediately, with no clock edge required.
- Run and wrap (TICK_DIV=8, Speed=0, Dir=0, Enable=1):
  - Running rises one cycle after Enable.
  - Sel steps 0,1,2,3,4,0 at 8-cycle intervals.
  - Tick pulses 1 cycle each time; Wrap=1 only on 4->0.
- Retreat and speed (Dir=1, Speed=1): Sel from 0 -> 4 (Wrap=1), 3, 2 at 4-cycle intervals.
- Speed drop mid-count (Speed 0->2) while prescaler=5 -> advance on the next edge, prescaler=0, then 2-cycle intervals.
- Pause/step (Enable=0 at Sel=2, then three StepReq pulses with Dir=0) -> Sel 3, 4, 0; Wrap on the third pulse. StepReq while RUN -> no change. StepReq coincident with terminal -> single advance.
- Bounce build (HELLO_SCROLL_BOUNCE_EN, TICK_DIV=8, Dir=0) -> Sel 0,1,2,3,4,3,2,1,0,1; Wrap on the 4->3 and 0->1 steps. Reset mid-sequence returns Sel=0 and the flag to advancing.
